// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
//   Drives a W-bit bank of external JK flip-flops to a requested target word.
//   Per bit, J/K come from the JK excitation table applied to the bank state
//   read back on q_fb. After each drive pulse the bank is compared with the
//   target. On a mismatch the block drives again, up to MAX_RETRY extra times.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   target handshake (in_ready is high only in IDLE)
//   in_target [W]       requested bank state
//   q_fb [W]            current Q of the external bank
//   j, k [W]            registered J/K drive to the bank
//   out_valid/out_ready result handshake
//   out_err             target not reached after all attempts
//   out_retries         extra attempts used (0 = first drive succeeded)

// One bit of the excitation table. Don't-care entries are resolved by MODE:
//   MODE 0 gives set/reset (J=t, K=~t), and MODE 1 gives toggle (J=K=1).
module jk_excite_lane #(
  parameter int MODE = 0
) (
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);
  always_comb begin
    j = 1'b0;
    k = 1'b0;
    if (q != t) begin
      if (MODE == 0) begin
        j = t;
        k = ~t;
      end else begin
        j = 1'b1;
        k = 1'b1;
      end
    end
  end
endmodule

module jk_excitation_driver #(
  parameter int W         = 4,
  parameter int MODE      = 0,
  parameter int MAX_RETRY = 2,
  localparam int RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_target,
  input  logic [W-1:0]  q_fb,
  output logic [W-1:0]  j,
  output logic [W-1:0]  k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_err,
  output logic [RW-1:0] out_retries
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, RESP} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   tgt, tgt_nx;
  logic [RW-1:0]  retry, retry_nx;
  logic           err_nx;
  logic [W-1:0]   j_nx, k_nx;
  logic [W-1:0]   exc_tgt, j_ex, k_ex;

  // In IDLE the excitation is computed against the incoming word, because it
  // is registered on the same edge the word is latched. Later (retries) it
  // uses the stored target.
  assign exc_tgt = (state == IDLE) ? in_target : tgt;

  for (genvar i = 0; i < W; i++) begin : g_lane
    jk_excite_lane #(.MODE(MODE)) u_lane (
      .q (q_fb[i]),
      .t (exc_tgt[i]),
      .j (j_ex[i]),
      .k (k_ex[i])
    );
  end

  // Status outputs decode straight from the state register. Reset therefore
  // drops out_valid at once, together with j/k.
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == RESP);
  assign out_retries = retry;

  always_comb begin
    state_nx = state;
    tgt_nx   = tgt;
    retry_nx = retry;
    err_nx   = out_err;
    // j/k are non-zero only for the single DRIVE cycle after they are loaded.
    j_nx     = '0;
    k_nx     = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          tgt_nx   = in_target;
          retry_nx = '0;
          j_nx     = j_ex;
          k_nx     = k_ex;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        // The bank samples j/k at this closing edge.
        state_nx = CHECK;
      end
      CHECK: begin
        if (q_fb == tgt) begin
          err_nx   = 1'b0;
          state_nx = RESP;
        end else if (retry < RW'(MAX_RETRY)) begin
          retry_nx = retry + RW'(1);
          j_nx     = j_ex;
          k_nx     = k_ex;
          state_nx = DRIVE;
        end else begin
          err_nx   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tgt     <= '0;
      retry   <= '0;
      out_err <= 1'b0;
      j       <= '0;
      k       <= '0;
    end else begin
      state   <= state_nx;
      tgt     <= tgt_nx;
      retry   <= retry_nx;
      out_err <= err_nx;
      j       <= j_nx;
      k       <= k_nx;
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
module tb_jk_excitation_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, load;
  logic [3:0] in_target, load_val, stuck0;
  logic [3:0] bank0, bank1, j0, k0, j1, k1;
  logic       in_ready0, in_ready1, ov0, ov1, err0, err1;
  logic [1:0] rt0, rt1;

  always #5 clk = ~clk;

  jk_excitation_driver #(.W(4), .MODE(0), .MAX_RETRY(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_target(in_target), .q_fb(bank0), .j(j0), .k(k0),
    .out_valid(ov0), .out_ready(out_ready), .out_err(err0), .out_retries(rt0));

  jk_excitation_driver #(.W(4), .MODE(1), .MAX_RETRY(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_target(in_target), .q_fb(bank1), .j(j1), .k(k1),
    .out_valid(ov1), .out_ready(out_ready), .out_err(err1), .out_retries(rt1));

  // External JK bank model. Bits set in stuck0 are held at 0 in bank0.
  function automatic logic [3:0] jk_next(input logic [3:0] q, jj, kk);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      case ({jj[i], kk[i]})
        2'b10:   n[i] = 1'b1;
        2'b01:   n[i] = 1'b0;
        2'b11:   n[i] = ~q[i];
        default: n[i] = q[i];
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (load) begin
      bank0 <= load_val;
      bank1 <= load_val;
    end else begin
      bank0 <= jk_next(bank0, j0, k0) & ~stuck0;
      bank1 <= jk_next(bank1, j1, k1);
    end
  end

  int cyc = 0;
  int pulses = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (j0[0]) pulses <= pulses + 1;

  typedef struct {
    logic       err;
    logic [1:0] rt;
    int         acc;
    int         lat;
    logic [3:0] bank;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  bit   seen = 1'b0;
  int   tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for u0. On the first cycle of out_valid it pops an entry and
  // checks the result and latency. On later cycles it checks that the result
  // stays stable.
  always @(negedge clk) begin
    if (!rst_n || !ov0) seen = 1'b0;
    else if (!seen) begin
      seen = 1'b1;
      if (sbq.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
      else begin
        cur = sbq.pop_front();
        chk("out_err", err0, cur.err);
        chk("out_retries", rt0, cur.rt);
        chk("latency", cyc - cur.acc, cur.lat);
        chk("bank_at_resp", bank0, cur.bank);
      end
    end else begin
      chk("hold_err", err0, cur.err);
      chk("hold_retries", rt0, cur.rt);
    end
  end

  task automatic load_bank(input logic [3:0] v);
    @(negedge clk);
    load = 1'b1; load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Offer one target, queue the expected result, and check u0's drive
  // during the DRIVE cycle. Returns at the negedge inside DRIVE.
  task automatic send(input logic [3:0] t, input logic eerr, input logic [1:0] ert,
                      input logic [3:0] ebank, input logic [3:0] ej, input logic [3:0] ek);
    int n = 0;
    while (!in_ready0 && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_wait", in_ready0, 1'b1);
    in_valid = 1'b1; in_target = t;
    sbq.push_back('{eerr, ert, cyc + 1, 2 * (int'(ert) + 1), ebank});
    @(negedge clk);
    in_valid = 1'b0;
    chk("j_drive", j0, ej);
    chk("k_drive", k0, ek);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sbq.size() != 0 || ov0) && n < 40) begin @(negedge clk); n++; end
    chk("done_timeout", n < 40, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; load = 1'b0;
    stuck0 = 4'b0; in_target = 4'b0; load_val = 4'b0;
    load_bank(4'b0000);
    @(negedge clk);
    chk("rst_j", j0, 4'b0);
    chk("rst_k", k0, 4'b0);
    chk("rst_out_valid", ov0, 1'b0);
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_out_err", err0, 1'b0);
    chk("rst_retries", rt0, 2'd0);
    rst_n = 1'b1;

    // MODE0 set from 0000, MODE1 toggles the same bits.
    load_bank(4'b0000);
    send(4'b1010, 1'b0, 2'd0, 4'b1010, 4'b1010, 4'b0000);
    chk("m1_j", j1, 4'b1010);
    chk("m1_k", k1, 4'b1010);
    wait_done();
    chk("m1_bank", bank1, 4'b1010);

    // Mixed set/reset versus toggle.
    load_bank(4'b1100);
    send(4'b1010, 1'b0, 2'd0, 4'b1010, 4'b0010, 4'b0100);
    chk("m1_j_mix", j1, 4'b0110);
    chk("m1_k_mix", k1, 4'b0110);
    wait_done();
    chk("m1_bank_mix", bank1, 4'b1010);
    chk("m1_err_mix", err1, 1'b0);

    // Bit 0 stuck at 0: three drives, then error, with latency 6.
    stuck0 = 4'b0001;
    load_bank(4'b0000);
    p0 = pulses;
    send(4'b0001, 1'b1, 2'd2, 4'b0000, 4'b0001, 4'b0000);
    wait_done();
    chk("stuck_pulses", pulses - p0, 32'd3);
    stuck0 = 4'b0000;

    // Back-pressure: the result is held, and new offers are ignored.
    load_bank(4'b1010);
    out_ready = 1'b0;
    send(4'b0101, 1'b0, 2'd0, 4'b0101, 4'b0101, 4'b1010);
    n = 0;
    while (!ov0 && n < 20) begin @(negedge clk); n++; end
    chk("bp_out_valid_rise", ov0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_target = 4'b1111;
      @(negedge clk);
      chk("bp_in_ready_low", in_ready0, 1'b0);
      chk("bp_out_valid_held", ov0, 1'b1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", in_ready0, 1'b1);
    chk("bp_out_valid_drop", ov0, 1'b0);
    @(negedge clk);
    chk("bp_no_drive", j0 | k0, 4'b0);
    chk("bp_bank", bank0, 4'b0101);

    // Reset in the middle of DRIVE.
    load_bank(4'b0000);
    send(4'b1111, 1'b0, 2'd0, 4'b1111, 4'b1111, 4'b0000);
    rst_n = 1'b0;
    #1;
    chk("arst_j", j0, 4'b0);
    chk("arst_k", k0, 4'b0);
    chk("arst_j1k1", j1 | k1, 4'b0);
    chk("arst_out_valid", ov0, 1'b0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", in_ready0, 1'b1);
    chk("arst_bank0", bank0, 4'b0000);
    chk("arst_bank1", bank1, 4'b0000);

    // Target equals the current bank state.
    load_bank(4'b0110);
    send(4'b0110, 1'b0, 2'd0, 4'b0110, 4'b0000, 4'b0000);
    wait_done();

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Inverse side of the JK flip-flop: accepts a target state word and drives a W-bit bank of external JK flip-flops to it.
- Derives J/K per bit from the JK excitation table, using the current bank state read back on q_fb.
- Verifies the bank reached the target and retries on mismatch.
- Sits between a sequencing controller (valid/ready in and out) and a bank of JK flip-flops clocked on the same clk.

Parameters:
W, 4, width of target word and JK bank.
MODE, 0, don't-care resolution: 0 = set/reset style, 1 = toggle style.
MAX_RETRY, 2, extra drive attempts after the first before reporting error.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  target word offered.
in_ready  output  1  high only in IDLE.
in_target  input  W  requested bank state.
q_fb  input  W  current Q outputs of the external JK bank.
j  output  W  registered J drive to bank.
k  output  W  registered K drive to bank.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_err  output  1  1 = target not reached after all attempts.
out_retries  output  clog2(MAX_RETRY+1)  retries used (0 = first attempt succeeded).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; j=0, k=0, out_valid=0, out_err=0, out_retries=0, target register=0, retry count=0. Reset dominates any state, including mid-DRIVE; j/k drop to 0 immediately, so the bank holds.
- Excitation per bit (q = q_fb[i], t = target[i]):
  - q=0,t=0 -> J=0,K=0.
  - q=1,t=1 -> J=0,K=0.
  - q=0,t=1 -> MODE0: J=1,K=0; MODE1: J=1,K=1.
  - q=1,t=0 -> MODE0: J=0,K=1; MODE1: J=1,K=1.
- States: IDLE, DRIVE, CHECK, RESP.
- IDLE:
  - in_ready=1, j=k=0.
  - On in_valid at an edge: latch in_target, clear retry count, register j/k computed from q_fb and in_target, go DRIVE.
- DRIVE (exactly 1 cycle):
  - j/k held stable; the bank samples them at the closing edge.
  - At that edge j,k <= 0 and state -> CHECK.
- CHECK (1 cycle): q_fb reflects the bank update. Compare q_fb to the target register:
  - Equal: go RESP with out_err=0.
  - Unequal and retry count < MAX_RETRY: increment retry count, register new j/k from the current q_fb, go DRIVE.
  - Unequal and retry count == MAX_RETRY: go RESP with out_err=1.
- RESP:
  - out_valid=1; out_err and out_retries stable; j=k=0.
  - Held until out_valid && out_ready at an edge, then -> IDLE, out_valid=0.
- Latency:
  - Accept at edge E0 -> out_valid high after E2 on first-try success.
  - Each retry adds 2 cycles.
  - Maximum is 2*(MAX_RETRY+1) cycles from accept to out_valid.
- Flow control:
  - in_valid outside IDLE is ignored and in_ready=0; there is no queuing.
  - A new request can be accepted on the cycle after the RESP handshake edge, not on the same edge.
- Target equal to current state: j=k=0 during DRIVE, success with out_retries=0 at E2.
- j and k are register outputs; no combinational path from q_fb to j/k.

Test Plan:
- MODE=0, bank q=0000, target 1010 -> during DRIVE j=1010, k=0000; out_valid at E2; out_err=0, out_retries=0; bank=1010.
- MODE=1, bank q=1100, target 1010 -> during DRIVE j=0110, k=0110; bank=1010; out_err=0.
- Bank bit0 stuck at 0, target 0001, MAX_RETRY=2 -> three DRIVE pulses with j[0]=1; out_valid at E6 with out_err=1, out_retries=2.
- Success, out_ready held low 5 cycles -> out_valid, out_err, out_retries stable for all 5; in_ready=0 and in_valid ignored; IDLE after the handshake.
- rst_n asserted low mid-DRIVE -> j=k=0 and out_valid=0 immediately (before the next edge); after release: IDLE, in_ready=1, bank unchanged by the aborted drive.
- Target equals bank (0110 with q=0110) -> j=k=0 in DRIVE; out_valid at E2; out_err=0, out_retries=0.
